frame_demux: RTL and testbench

//  Receive end of the 4-slot tagged word stream built by the registered slot mux.

---
 rtl/frame_demux_if.sv | 25 ++
 rtl/frame_demux.sv | 153 +++++++++++++++
 tb/tb_frame_demux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/frame_demux_if.sv
// Stream and frame-output bundle for frame_demux.
// The master side drives the word stream; the slave side returns rebuilt slots and status.
interface frame_demux_if #(
   parameter int DW = 4
);
   logic          en;
   logic [DW:0]   din;
   logic [DW-1:0] d1;
   logic [DW-1:0] d2;
   logic [DW-1:0] d3;
   logic [DW-1:0] d4;
   logic          frame_valid;
   logic          locked;
   logic          sync_err;

   modport master (
      output en, din,
      input  d1, d2, d3, d4, frame_valid, locked, sync_err
   );

   modport slave (
      input  en, din,
      output d1, d2, d3, d4, frame_valid, locked, sync_err
   );
endinterface

// File: rtl/frame_demux.sv
// Receive side of the 4-slot tagged word stream: finds COM alignment, checks slot order,
// and publishes d1..d4 once LOCK_FRAMES consecutive good frames have been seen.
module frame_demux #(
   parameter int DW          = 4,
   parameter int LOCK_FRAMES = 2
) (
   input  logic         clk,
   input  logic         rst,
   frame_demux_if.slave bus
);
   localparam int            CW       = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_FRAMES);

   typedef enum logic [2:0] {
      HUNT,
      EXP_A,
      EXP_B,
      EXP_C,
      EXP_COM
   } state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c >= LOCK_MAX) return LOCK_MAX;
      return c + CW'(1);
   endfunction

   state_t        state, state_nx;
   logic [CW-1:0] lock_cnt, lock_cnt_nx;

   logic [DW-1:0] sh1_p0, sh2_p0, sh3_p0;
   logic [DW-1:0] sh1_nx, sh2_nx, sh3_nx;

   logic [DW-1:0] d1_p1, d2_p1, d3_p1, d4_p1;
   logic [DW-1:0] d1_nx, d2_nx, d3_nx, d4_nx;
   logic          vld_p1, vld_nx;
   logic          err_p1, err_nx;
   logic          lock_p1, lock_nx;

   logic          tag;
   logic [DW-1:0] data;

   assign tag  = bus.din[DW];
   assign data = bus.din[DW-1:0];

   // Stage p0: slot sequencing into shadow registers
   always_comb begin
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      sh1_nx      = sh1_p0;
      sh2_nx      = sh2_p0;
      sh3_nx      = sh3_p0;
      d1_nx       = d1_p1;
      d2_nx       = d2_p1;
      d3_nx       = d3_p1;
      d4_nx       = d4_p1;
      vld_nx      = 1'b0;
      err_nx      = 1'b0;

      if (bus.en) begin
         case (state)
            HUNT: begin
               if (!tag) begin
                  sh1_nx   = data;
                  state_nx = EXP_A;
               end
            end
            EXP_A, EXP_B, EXP_C: begin
               if (!tag) begin
                  // Out-of-place COM restarts alignment on this word
                  err_nx      = 1'b1;
                  lock_cnt_nx = '0;
                  sh1_nx      = data;
                  state_nx    = EXP_A;
               end else if (state == EXP_A) begin
                  sh2_nx   = data;
                  state_nx = EXP_B;
               end else if (state == EXP_B) begin
                  sh3_nx   = data;
                  state_nx = EXP_C;
               end else begin
                  lock_cnt_nx = sat_inc(lock_cnt);
                  state_nx    = EXP_COM;
                  if (lock_cnt_nx == LOCK_MAX) begin
                     d1_nx  = sh1_p0;
                     d2_nx  = sh2_p0;
                     d3_nx  = sh3_p0;
                     d4_nx  = data;
                     vld_nx = 1'b1;
                  end
               end
            end
            EXP_COM: begin
               if (!tag) begin
                  sh1_nx   = data;
                  state_nx = EXP_A;
               end else begin
                  err_nx      = 1'b1;
                  lock_cnt_nx = '0;
                  state_nx    = HUNT;
               end
            end
            default: state_nx = HUNT;
         endcase
      end

      lock_nx = (lock_cnt_nx == LOCK_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         lock_cnt <= '0;
         sh1_p0   <= '0;
         sh2_p0   <= '0;
         sh3_p0   <= '0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_cnt_nx;
         sh1_p0   <= sh1_nx;
         sh2_p0   <= sh2_nx;
         sh3_p0   <= sh3_nx;
      end
   end

   // Stage p1: published frame and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         d1_p1   <= '0;
         d2_p1   <= '0;
         d3_p1   <= '0;
         d4_p1   <= '0;
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         lock_p1 <= 1'b0;
      end else begin
         d1_p1   <= d1_nx;
         d2_p1   <= d2_nx;
         d3_p1   <= d3_nx;
         d4_p1   <= d4_nx;
         vld_p1  <= vld_nx;
         err_p1  <= err_nx;
         lock_p1 <= lock_nx;
      end
   end

   assign bus.d1          = d1_p1;
   assign bus.d2          = d2_p1;
   assign bus.d3          = d3_p1;
   assign bus.d4          = d4_p1;
   assign bus.frame_valid = vld_p1;
   assign bus.sync_err    = err_p1;
   assign bus.locked      = lock_p1;
endmodule

// File: tb/tb_frame_demux.sv
// Directed bench for frame_demux: a vector table over two instances (LOCK_FRAMES=2 and 1)
// plus a hand-written gapped-strobe stream.
module tb_frame_demux;
   logic clk = 1'b0;
   logic rst0, rst1;

   always #5 clk = ~clk;

   frame_demux_if #(.DW(4)) b0 ();
   frame_demux_if #(.DW(4)) b1 ();

   frame_demux #(.DW(4), .LOCK_FRAMES(2)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
   frame_demux #(.DW(4), .LOCK_FRAMES(1)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));

   typedef struct {
      int          u;
      int          tn;
      logic        rst;
      logic        en;
      logic [4:0]  din;
      logic        fv;
      logic        se;
      logic        lk;
      logic [15:0] d;
   } vec_t;

   vec_t vt[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input int u, input int tn, input logic r, input logic e, input logic [4:0] w,
                      input logic fv, input logic se, input logic lk, input logic [15:0] d);
      vt.push_back('{u, tn, r, e, w, fv, se, lk, d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18:0] observe(input int u);
      if (u == 0) return {b0.d1, b0.d2, b0.d3, b0.d4, b0.frame_valid, b0.sync_err, b0.locked};
      return {b1.d1, b1.d2, b1.d3, b1.d4, b1.frame_valid, b1.sync_err, b1.locked};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got d=%h fv=%b se=%b lk=%b, want d=%h fv=%b se=%b lk=%b", name,
                  act[18:3], act[2], act[1], act[0], exp[18:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t  v;
      string nm;
      v = vt[idx];
      rst0 = 1'b0; rst1 = 1'b0;
      b0.en = 1'b0; b1.en = 1'b0;
      if (v.u == 0) begin
         rst0 = v.rst; b0.en = v.en; b0.din = v.din;
      end else begin
         rst1 = v.rst; b1.en = v.en; b1.din = v.din;
      end
      tick();
      nm = $sformatf("u%0d_t%0d_v%0d", v.u, v.tn, idx);
      check(nm, observe(v.u), {v.d, v.fv, v.se, v.lk});
   endtask

   logic [4:0] s5 [10];
   int fv_cnt, se_cnt;

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      b0.en = 1'b0; b0.din = '0;
      b1.en = 1'b0; b1.din = '0;
      tick();

      // t1: reset with live strobe
      add(0,1,1,1,5'h05, 0,0,0,16'h0000);
      add(0,1,1,1,5'h05, 0,0,0,16'h0000);
      // t2: hunt then two frames
      add(0,2,0,1,5'h1A, 0,0,0,16'h0000);
      add(0,2,0,1,5'h1B, 0,0,0,16'h0000);
      add(0,2,0,1,5'h01, 0,0,0,16'h0000);
      add(0,2,0,1,5'h12, 0,0,0,16'h0000);
      add(0,2,0,1,5'h13, 0,0,0,16'h0000);
      add(0,2,0,1,5'h14, 0,0,0,16'h0000);
      add(0,2,0,1,5'h01, 0,0,0,16'h0000);
      add(0,2,0,1,5'h12, 0,0,0,16'h0000);
      add(0,2,0,1,5'h13, 0,0,0,16'h0000);
      add(0,2,0,1,5'h14, 1,0,1,16'h1234);
      add(0,2,0,0,5'h00, 0,0,1,16'h1234);
      // t3: early COM in slot B
      add(0,3,0,1,5'h05, 0,0,1,16'h1234);
      add(0,3,0,1,5'h16, 0,0,1,16'h1234);
      add(0,3,0,1,5'h07, 0,1,0,16'h1234);
      add(0,3,0,1,5'h18, 0,0,0,16'h1234);
      add(0,3,0,1,5'h19, 0,0,0,16'h1234);
      add(0,3,0,1,5'h1A, 0,0,0,16'h1234);
      add(0,3,0,1,5'h02, 0,0,0,16'h1234);
      add(0,3,0,1,5'h13, 0,0,0,16'h1234);
      add(0,3,0,1,5'h14, 0,0,0,16'h1234);
      add(0,3,0,1,5'h15, 1,0,1,16'h2345);
      // t4: data word where COM expected
      add(0,4,0,1,5'h03, 0,0,1,16'h2345);
      add(0,4,0,1,5'h14, 0,0,1,16'h2345);
      add(0,4,0,1,5'h15, 0,0,1,16'h2345);
      add(0,4,0,1,5'h16, 1,0,1,16'h3456);
      add(0,4,0,1,5'h18, 0,1,0,16'h3456);
      add(0,4,0,1,5'h19, 0,0,0,16'h3456);
      add(0,4,0,1,5'h1A, 0,0,0,16'h3456);
      add(0,4,0,1,5'h1B, 0,0,0,16'h3456);
      add(0,4,0,1,5'h04, 0,0,0,16'h3456);
      // t6: relock, then reset while in EXP_B
      add(0,6,0,1,5'h15, 0,0,0,16'h3456);
      add(0,6,0,1,5'h16, 0,0,0,16'h3456);
      add(0,6,0,1,5'h17, 0,0,0,16'h3456);
      add(0,6,0,1,5'h01, 0,0,0,16'h3456);
      add(0,6,0,1,5'h12, 0,0,0,16'h3456);
      add(0,6,0,1,5'h13, 0,0,0,16'h3456);
      add(0,6,0,1,5'h14, 1,0,1,16'h1234);
      add(0,6,0,1,5'h05, 0,0,1,16'h1234);
      add(0,6,0,1,5'h16, 0,0,1,16'h1234);
      add(0,6,1,1,5'h05, 0,0,0,16'h0000);
      add(0,6,0,1,5'h06, 0,0,0,16'h0000);
      add(0,6,0,1,5'h17, 0,0,0,16'h0000);
      add(0,6,0,1,5'h18, 0,0,0,16'h0000);
      add(0,6,0,1,5'h19, 0,0,0,16'h0000);
      add(0,6,0,1,5'h06, 0,0,0,16'h0000);
      add(0,6,0,1,5'h17, 0,0,0,16'h0000);
      add(0,6,0,1,5'h18, 0,0,0,16'h0000);
      add(0,6,0,1,5'h19, 1,0,1,16'h6789);
      // LOCK_FRAMES=1 instance
      add(1,7,1,1,5'h05, 0,0,0,16'h0000);
      add(1,7,0,1,5'h01, 0,0,0,16'h0000);
      add(1,7,0,1,5'h12, 0,0,0,16'h0000);
      add(1,7,0,1,5'h13, 0,0,0,16'h0000);
      add(1,7,0,1,5'h14, 1,0,1,16'h1234);
      add(1,7,0,1,5'h05, 0,0,1,16'h1234);
      add(1,7,0,1,5'h16, 0,0,1,16'h1234);
      add(1,7,0,1,5'h07, 0,1,0,16'h1234);
      add(1,7,0,1,5'h18, 0,0,0,16'h1234);
      add(1,7,0,1,5'h19, 0,0,0,16'h1234);
      add(1,7,0,1,5'h1A, 1,0,1,16'h789A);
      add(1,7,0,0,5'h1B, 0,0,1,16'h789A);

      for (int i = 0; i < vt.size(); i++) run_vec(i);

      // t5: test 2 stream with random strobe gaps and junk on din while idle
      s5 = '{5'h1A, 5'h1B, 5'h01, 5'h12, 5'h13, 5'h14, 5'h01, 5'h12, 5'h13, 5'h14};
      rst1 = 1'b0; b1.en = 1'b0;
      rst0 = 1'b1; b0.en = 1'b1; b0.din = 5'h05;
      tick();
      tick();
      rst0 = 1'b0;
      fv_cnt = 0;
      se_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            b0.en = 1'b0;
            b0.din = 5'($urandom);
            tick();
            fv_cnt += int'(b0.frame_valid);
            se_cnt += int'(b0.sync_err);
         end
         b0.en = 1'b1;
         b0.din = s5[i];
         tick();
         fv_cnt += int'(b0.frame_valid);
         se_cnt += int'(b0.sync_err);
         if (i == 8) check("t5_prelock", observe(0), {16'h0000, 1'b0, 1'b0, 1'b0});
         if (i == 9) check("t5_frame", observe(0), {16'h1234, 1'b1, 1'b0, 1'b1});
      end
      b0.en = 1'b0;
      b0.din = 5'h00;
      tick();
      fv_cnt += int'(b0.frame_valid);
      check("t5_after", observe(0), {16'h1234, 1'b0, 1'b0, 1'b1});
      tick();
      fv_cnt += int'(b0.frame_valid);
      se_cnt += int'(b0.sync_err);
      check("t5_pulses", {3'b000, fv_cnt[7:0], se_cnt[7:0]}, {3'b000, 8'd1, 8'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
